// File: rtl/dispense_arbiter.sv
// dispense_arbiter: round-robin slot arbiter and dispense sequencer.
// Optional macro DISPENSE_TIMEOUT_EN adds a WAIT timeout with a sticky fault.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   req[2**N]          per-slot dispense request (level)
//   credit_ok          payment sufficient, sampled in IDLE
//   done               motor completion pulse, sampled in WAIT
//   sel[N]             granted slot index (decoder select)
//   sel_vld            sel valid (DISPENSE and WAIT)
//   dispense           one-cycle motor start pulse
//   ack[2**N]          one-hot completion pulse for the granted slot
//   busy               high outside IDLE
//   fault              sticky timeout flag (0 without the macro)
module dispense_arbiter #(
   parameter int N           = 2,
   parameter int HOLD_CYCLES = 4,
   parameter int TIMEOUT     = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [(1<<N)-1:0]   req,
   input  logic                credit_ok,
   input  logic                done,
   output logic [N-1:0]        sel,
   output logic                sel_vld,
   output logic                dispense,
   output logic [(1<<N)-1:0]   ack,
   output logic                busy,
   output logic                fault
);

   localparam int SLOTS = 1 << N;
   localparam int CW    = $clog2(HOLD_CYCLES + 1);

   if (HOLD_CYCLES < 1 || TIMEOUT < 1) begin : g_param_check
      $error("dispense_arbiter: HOLD_CYCLES and TIMEOUT must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE,
      DISPENSE,
      WAIT,
      COOL
   } state_t;

   state_t             state_q, state_d;
   logic [N-1:0]       sel_d;
   logic               vld_d;
   logic               disp_d;
   logic [SLOTS-1:0]   ack_d;
   logic               busy_d;
   logic [CW-1:0]      cool_q, cool_d;
   logic [N-1:0]       last_q, last_d;
   logic               pick_found;
   logic [N-1:0]       pick_idx;

`ifdef DISPENSE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0]      tmo_q, tmo_d;
   logic               fault_q, fault_d;
   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

   // Scan upward from the slot after the last grant; the final
   // iteration wraps back onto last_q itself.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int i = 1; i <= SLOTS; i++) begin
         if (!pick_found && req[last_q + N'(i)]) begin
            pick_found = 1'b1;
            pick_idx   = last_q + N'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel;
      vld_d   = 1'b0;
      disp_d  = 1'b0;
      ack_d   = '0;
      busy_d  = 1'b1;
      cool_d  = cool_q;
      last_d  = last_q;
`ifdef DISPENSE_TIMEOUT_EN
      tmo_d   = tmo_q;
      fault_d = fault_q;
`endif
      unique case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (pick_found && credit_ok) begin
               state_d = DISPENSE;
               sel_d   = pick_idx;
               vld_d   = 1'b1;
               disp_d  = 1'b1;
               busy_d  = 1'b1;
            end
         end
         DISPENSE: begin
            state_d = WAIT;
            vld_d   = 1'b1;
`ifdef DISPENSE_TIMEOUT_EN
            tmo_d   = '0;
`endif
         end
         WAIT: begin
            vld_d = 1'b1;
            if (done) begin
               vld_d   = 1'b0;
               ack_d   = SLOTS'(1) << sel;
               last_d  = sel;
               cool_d  = CW'(HOLD_CYCLES);
               state_d = COOL;
            end
`ifdef DISPENSE_TIMEOUT_EN
            else if (tmo_q == TW'(TIMEOUT - 1)) begin
               vld_d   = 1'b0;
               fault_d = 1'b1;
               last_d  = sel;
               cool_d  = CW'(HOLD_CYCLES);
               state_d = COOL;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
`endif
         end
         COOL: begin
            if (cool_q <= CW'(1)) begin
               cool_d  = '0;
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               cool_d = cool_q - CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sel      <= '0;
         sel_vld  <= 1'b0;
         dispense <= 1'b0;
         ack      <= '0;
         busy     <= 1'b0;
         cool_q   <= '0;
         last_q   <= '1;
`ifdef DISPENSE_TIMEOUT_EN
         tmo_q    <= '0;
         fault_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         sel      <= sel_d;
         sel_vld  <= vld_d;
         dispense <= disp_d;
         ack      <= ack_d;
         busy     <= busy_d;
         cool_q   <= cool_d;
         last_q   <= last_d;
`ifdef DISPENSE_TIMEOUT_EN
         tmo_q    <= tmo_d;
         fault_q  <= fault_d;
`endif
      end
   end

endmodule

// File: tb/tb_dispense_arbiter.sv
// tb_dispense_arbiter: directed and randomized transactions against
// a transaction-level model of the round-robin dispense arbiter.
module tb_dispense_arbiter;

   localparam int HOLD = 4;
   localparam int TMO  = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic       credit_ok;
   logic       done;
   logic [1:0] sel;
   logic       sel_vld;
   logic       dispense;
   logic [3:0] ack;
   logic       busy;
   logic       fault;

   int vectors    = 0;
   int miscompares = 0;
   int last       = 3;
   int cur_sel    = 0;
   logic fault_exp = 1'b0;
   int cyc        = 0;

   dispense_arbiter #(
      .N(2),
      .HOLD_CYCLES(HOLD),
      .TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req(req),
      .credit_ok(credit_ok),
      .done(done),
      .sel(sel),
      .sel_vld(sel_vld),
      .dispense(dispense),
      .ack(ack),
      .busy(busy),
      .fault(fault)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int e_sel,
                          input logic e_vld, input logic e_disp,
                          input logic [3:0] e_ack, input logic e_busy);
      chk({tag, ".sel"}, 32'(sel), 32'(e_sel));
      chk({tag, ".sel_vld"}, 32'(sel_vld), 32'(e_vld));
      chk({tag, ".dispense"}, 32'(dispense), 32'(e_disp));
      chk({tag, ".ack"}, 32'(ack), 32'(e_ack));
      chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
      chk({tag, ".fault"}, 32'(fault), 32'(fault_exp));
   endtask

   // Round-robin rule: first requesting slot after the last grant.
   function automatic int pick(input logic [3:0] r);
      for (int i = 1; i <= 4; i++)
         if (r[(last + i) % 4]) return (last + i) % 4;
      return -1;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      req = '0;
      credit_ok = 1'b0;
      done = 1'b0;
      last = 3;
      cur_sel = 0;
      fault_exp = 1'b0;
      #1;
      chk_all("async_reset", 0, 0, 0, 4'b0, 0);
      tick();
      chk_all("in_reset", 0, 0, 0, 4'b0, 0);
      rst_n = 1'b1;
   endtask

   // pre: idle cycles with no eligible grant; w: WAIT cycles until done;
   // rst_at: reset before the given WAIT cycle (0 = never).
   task automatic run_txn(input logic [3:0] r, input int pre,
                          input int w, input int rst_at,
                          output int gcyc);
      int exp;
      logic [3:0] oh;
      gcyc = 0;
      for (int i = 0; i < pre; i++) begin
         if ($urandom_range(1, 0) == 1) begin
            req = r;
            credit_ok = 1'b0;
         end else begin
            req = '0;
            credit_ok = 1'b1;
         end
         done = 1'($urandom);
         tick();
         chk_all("idle", cur_sel, 0, 0, 4'b0, 0);
      end
      req = r;
      credit_ok = 1'b1;
      done = 1'($urandom);
      exp = pick(r);
      tick();
      gcyc = cyc;
      cur_sel = exp;
      chk_all("grant", exp, 1, 1, 4'b0, 1);
      req = 4'($urandom);
      credit_ok = 1'($urandom);
      done = 1'($urandom);
      tick();
      chk_all("wait_entry", exp, 1, 0, 4'b0, 1);
      for (int i = 1; i <= w; i++) begin
         if (rst_at == i) begin
            do_reset();
            return;
         end
         req = 4'($urandom);
         credit_ok = 1'($urandom);
         done = (i == w);
         tick();
         if (i < w) begin
            chk_all("wait", exp, 1, 0, 4'b0, 1);
         end else begin
            oh = 4'b0001 << exp;
            chk_all("ack", exp, 0, 0, oh, 1);
            last = exp;
         end
      end
      for (int i = 1; i <= HOLD; i++) begin
         req = 4'($urandom);
         credit_ok = 1'($urandom);
         done = 1'($urandom);
         tick();
         chk_all("cool", exp, 0, 0, 4'b0, i < HOLD);
      end
      done = 1'b0;
   endtask

   initial begin
      int g;
      int prev;
      rst_n = 1'b0;
      req = '0;
      credit_ok = 1'b0;
      done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 0, 0, 0, 4'b0, 0);
      rst_n = 1'b1;
      tick();
      chk_all("post_reset", 0, 0, 0, 4'b0, 0);

      run_txn(4'b0001, 0, 3, 0, g);

      do_reset();
      prev = 0;
      for (int k = 0; k < 5; k++) begin
         run_txn(4'b1111, 0, 2, 0, g);
         chk("rr_order", 32'(cur_sel), 32'(k % 4));
         if (k > 0) chk("grant_period", 32'(g - prev), 32'd8);
         prev = g;
      end

      req = 4'b0100;
      credit_ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         done = 1'($urandom);
         tick();
         chk_all("no_credit", cur_sel, 0, 0, 4'b0, 0);
      end
      run_txn(4'b0100, 0, 1, 0, g);
      chk("credit_slot", 32'(cur_sel), 32'd2);

      run_txn(4'b1000, 0, 4, 2, g);
      run_txn(4'b1000, 0, 2, 0, g);
      chk("after_reset_slot", 32'(cur_sel), 32'd3);

      for (int t = 0; t < 40; t++) begin
         run_txn(4'($urandom_range(15, 1)), $urandom_range(3, 0),
                 $urandom_range(5, 1), 0, g);
      end

`ifdef DISPENSE_TIMEOUT_EN
      do_reset();
      req = 4'b0010;
      credit_ok = 1'b1;
      tick();
      cur_sel = 1;
      chk_all("to_grant", 1, 1, 1, 4'b0, 1);
      req = 4'b0;
      tick();
      chk_all("to_wait_entry", 1, 1, 0, 4'b0, 1);
      for (int i = 1; i <= TMO; i++) begin
         done = 1'b0;
         tick();
         if (i < TMO) begin
            chk_all("to_wait", 1, 1, 0, 4'b0, 1);
         end else begin
            fault_exp = 1'b1;
            chk_all("timeout", 1, 0, 0, 4'b0, 1);
            last = 1;
         end
      end
      for (int i = 1; i <= HOLD; i++) begin
         tick();
         chk_all("to_cool", 1, 0, 0, 4'b0, i < HOLD);
      end
      run_txn(4'b0011, 0, 2, 0, g);
      chk("to_rotate", 32'(cur_sel), 32'd0);
      do_reset();
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dispense_arbiter.md
# dispense_arbiter

Round-robin arbiter and sequencer for the product-slot dispense path of the vending machine. Accepts 2**N slot requests, grants one at a time when payment credit is valid, and drives the binary slot index consumed by the N-to-2**N select decoder. Runs a dispense handshake with the motor driver, and enforces a cooldown before the next grant.

## Interface
- N, 2: select width; slot count = 2**N.
- HOLD_CYCLES, 4: cooldown length in cycles after each dispense; must be ≥1.
- TIMEOUT, 255: WAIT-state cycle limit; used only with DISPENSE_TIMEOUT_EN; must be ≥1.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  2**N  per-slot dispense request, level.
- credit_ok  in  1  payment sufficient; sampled only in IDLE.
- done  in  1  motor completion, one-cycle pulse; sampled only in WAIT.
- sel  out  N  granted slot index, wired to the decoder select input.
- sel_vld  out  1  sel is valid; high in DISPENSE and WAIT.
- dispense  out  1  one-cycle motor start pulse.
- ack  out  2**N  one-hot, one-cycle completion pulse for the granted slot.
- busy  out  1  high in every state except IDLE.
- fault  out  1  sticky timeout flag; constant 0 without DISPENSE_TIMEOUT_EN.

## Operation
- States: IDLE, DISPENSE, WAIT, COOL. All outputs are registered.
- IDLE: if (|req) and credit_ok, pick the first set req bit, scanning from last_grant+1 upward and wrapping modulo 2**N. Load sel with that index, go to DISPENSE. Otherwise stay in IDLE.
- DISPENSE: dispense=1 for exactly this cycle, then go to WAIT unconditionally. done is ignored here.
- WAIT: on done, pulse ack[sel] for one cycle, set last_grant=sel, load the cooldown counter with HOLD_CYCLES, go to COOL.
- COOL: decrement the counter; on reaching 0, go to IDLE. The cycle after entering IDLE is eligible for a new grant.
- sel holds its value through COOL and IDLE until the next grant. Downstream qualifies it with sel_vld.
- Requests dropped or raised after a grant have no effect on the current transaction. A dropped request is simply not chosen later.
- done arriving in IDLE, DISPENSE or COOL is ignored.
- credit_ok deasserting after a grant does not abort the transaction.
- Reset, asynchronous and at any point including mid-transaction: state=IDLE, sel=0, sel_vld=0, dispense=0, ack=0, busy=0, fault=0, cooldown counter=0, last_grant=2**N-1. After reset, slot 0 has top priority.
- Counter widths: cooldown counter is clog2(HOLD_CYCLES+1) bits; timeout counter is clog2(TIMEOUT+1) bits. Neither counter wraps.

## Timing
- Grant latency: req and credit_ok high at edge k (state IDLE) → sel, sel_vld and dispense high after edge k. dispense falls after edge k+1.
- ack: done high at edge m in WAIT → ack[sel] high for the cycle after edge m; sel_vld falls in the same cycle.
- Minimum period between grants: 1 (DISPENSE) + W (WAIT, W≥1) + HOLD_CYCLES + 1 (IDLE) cycles.
- Fairness: with all requests held, grants rotate 0,1,…,2**N-1,0. No slot waits more than 2**N−1 grants.

## Configuration
- DISPENSE_TIMEOUT_EN defined:
  - The timeout counter clears on entry to WAIT and increments each WAIT cycle without done.
  - When it reaches TIMEOUT, fault is set (sticky until reset), no ack is issued, last_grant=sel, and the FSM goes to COOL.
  - If done and the timeout occur in the same cycle, done wins: ack is issued and fault is not set.
- DISPENSE_TIMEOUT_EN undefined:
  - No timeout counter is built; WAIT holds indefinitely until done.
  - fault is tied to 0.

## Test plan
- Reset then req=4'b0001, credit_ok=1 → sel=0 and dispense pulse one cycle later. done after 3 cycles → ack=4'b0001. busy stays high for 4 cooldown cycles.
- req=4'b1111 held, credit_ok=1, done returned 2 cycles after each dispense → grant order 0,1,2,3,0. Each grant is 1+2+4+1 cycles after the previous one.
- req=4'b0100, credit_ok=0 for 10 cycles → no dispense, busy=0. Raise credit_ok → sel=2 on the next cycle.
- rst_n pulled low during WAIT with sel=3 → all outputs 0 immediately. After release, req=4'b1000 → sel=3 granted normally, with no stale ack.
- Spurious done in IDLE and COOL, and req dropped during WAIT → no ack outside WAIT. The current transaction still completes with ack on its original slot.
- With DISPENSE_TIMEOUT_EN and TIMEOUT=8, no done → fault=1 after 8 WAIT cycles, no ack. The next grant rotates past the failed slot. fault stays 1 until reset.
